// File: rtl/vectorial_rf.sv
// Vector register file: 32 registers of WIDTH lanes x WIDTH bits.
// Three combinational read ports and one full-vector write port. Reset is synchronous.
module vectorial_rf #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [4:0]                   RS1,
   input  logic [4:0]                   RS2,
   input  logic [4:0]                   RS3,
   input  logic [4:0]                   RD,
   input  logic [WIDTH-1:0][WIDTH-1:0]  WD,
   input  logic                         WEV,
   output logic [WIDTH-1:0][WIDTH-1:0]  RD1,
   output logic [WIDTH-1:0][WIDTH-1:0]  RD2,
   output logic [WIDTH-1:0][WIDTH-1:0]  RD3
);

   logic [WIDTH-1:0][WIDTH-1:0] rf_q [32];

   // Reset wins over a write in the same cycle; v0 is an ordinary register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (WEV) begin
         rf_q[RD] <= WD;
      end
   end

   // Reads see stored contents only; no write-to-read bypass.
   assign RD1 = rf_q[RS1];
   assign RD2 = rf_q[RS2];
   assign RD3 = rf_q[RS3];

endmodule

// File: tb/tb_vectorial_rf.sv
// Self-checking bench for vectorial_rf: directed cases plus randomized traffic
// compared against a flat array-of-vectors reference model.
module tb_vectorial_rf;

   localparam int unsigned W  = 16;
   localparam int unsigned VB = W * W;

   logic                 clk;
   logic                 rst;
   logic [4:0]           rs1, rs2, rs3, rd;
   logic [W-1:0][W-1:0]  wd;
   logic                 wev;
   logic [W-1:0][W-1:0]  rd1, rd2, rd3;

   logic [VB-1:0] mdl [32];
   int unsigned n_vec;
   int unsigned n_err;

   vectorial_rf #(
      .WIDTH(W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .RS1 (rs1),
      .RS2 (rs2),
      .RS3 (rs3),
      .RD  (rd),
      .WD  (wd),
      .WEV (wev),
      .RD1 (rd1),
      .RD2 (rd2),
      .RD3 (rd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [VB-1:0] got, input logic [VB-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge, updating the model from the inputs held across it.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = '0;
      end else if (wev) begin
         mdl[rd] = wd;
      end
      #1;
   endtask

   task automatic check_reads(input string tag);
      #1;
      check({tag, "/rd1"}, rd1, mdl[rs1]);
      check({tag, "/rd2"}, rd2, mdl[rs2]);
      check({tag, "/rd3"}, rd3, mdl[rs3]);
   endtask

   function automatic logic [VB-1:0] splat(input logic [W-1:0] v);
      logic [VB-1:0] r;
      r = '0;
      for (int i = 0; i < int'(W); i++) r = r | (VB'(v) << (W * i));
      return r;
   endfunction

   task automatic write(input logic [4:0] a, input logic [VB-1:0] d);
      wev = 1'b1;
      rd  = a;
      wd  = d;
      tick();
      wev = 1'b0;
   endtask

   logic [VB-1:0] lane_idx;

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) mdl[i] = 'x;
      rst = 1'b1; wev = 1'b0; rd = '0; wd = '0;
      rs1 = '0; rs2 = '0; rs3 = '0;

      // Reset for two edges, then every register reads zero.
      tick();
      tick();
      rst = 1'b0;
      rs1 = 5'd0; rs2 = 5'd15; rs3 = 5'd31;
      #1;
      check("reset_rd1", rd1, '0);
      check("reset_rd2", rd2, '0);
      check("reset_rd3", rd3, '0);

      write(5'd1, splat(16'hCCCC));
      rs1 = 5'd1; rs2 = 5'd0; rs3 = 5'd0;
      #1;
      check("wr_v1", rd1, splat(16'hCCCC));
      check("wr_v1_v0a", rd2, '0);
      check("wr_v1_v0b", rd3, '0);

      wev = 1'b0; rd = 5'd2; wd = splat(16'hFFFF);
      tick();
      rs1 = 5'd2;
      #1;
      check("no_wev", rd1, '0);

      // No bypass: old value until the edge, new one after.
      lane_idx = '0;
      for (int i = 0; i < int'(W); i++) lane_idx = lane_idx | (VB'(i) << (W * i));
      rs1 = 5'd5; rs2 = 5'd5; rs3 = 5'd5;
      wev = 1'b1; rd = 5'd5;
      for (int i = 0; i < int'(W); i++) wd[i] = W'(i);
      #1;
      check("nobyp_rd1", rd1, '0);
      check("nobyp_rd2", rd2, '0);
      check("nobyp_rd3", rd3, '0);
      tick();
      wev = 1'b0;
      #1;
      check("lanes_rd1", rd1, lane_idx);
      check("lanes_rd2", rd2, lane_idx);
      check("lanes_rd3", rd3, lane_idx);

      write(5'd0, splat(16'hA5A5));
      write(5'd31, splat(16'hA5A5));
      rs1 = 5'd0; rs2 = 5'd31;
      #1;
      check("v0_writable", rd1, splat(16'hA5A5));
      check("v31_written", rd2, splat(16'hA5A5));
      rst = 1'b1; wev = 1'b1; rd = 5'd3; wd = splat(16'hBEEF);
      #1;
      check("rst_not_async", rd1, splat(16'hA5A5));
      tick();
      rst = 1'b0; wev = 1'b0;
      rs1 = 5'd0; rs2 = 5'd31; rs3 = 5'd3;
      #1;
      check("rst_clr_v0", rd1, '0);
      check("rst_clr_v31", rd2, '0);
      check("rst_beats_wev", rd3, '0);

      write(5'd7, splat(16'h1234));
      write(5'd7, splat(16'h5678));
      rs1 = 5'd7;
      #1;
      check("v7_last", rd1, splat(16'h5678));
      for (int a = 0; a < 32; a++) begin
         if (a != 7) begin
            rs2 = 5'(a);
            #1;
            check($sformatf("others_v%0d", a), rd2, '0);
         end
      end

      // Randomized traffic against the model, with occasional mid-run resets.
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 39) == 0);
         wev = $urandom_range(0, 1);
         rd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         for (int i = 0; i < int'(W); i++) wd[i] = W'($urandom);
         rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 7));
         rs2 = 5'($urandom);
         rs3 = ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 7));
         check_reads("rnd_pre");
         tick();
         rst = 1'b0;
         wev = 1'b0;
         check_reads("rnd_post");
      end

      for (int a = 0; a < 32; a++) begin
         rs1 = 5'(a);
         #1;
         check($sformatf("final_v%0d", a), rd1, mdl[a]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vectorial_rf.md
VECTORIAL_RF -- requirements
Module: vectorial_rf

Interface
REQ-001 SHALL have parameter WIDTH, default 16: lane width in bits and number of lanes per vector register.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port RS1, input, 5 bits: read address for port 1.
REQ-005 SHALL have port RS2, input, 5 bits: read address for port 2.
REQ-006 SHALL have port RS3, input, 5 bits: read address for port 3.
REQ-007 SHALL have port RD, input, 5 bits: write address.
REQ-008 SHALL have port WD, input, packed [WIDTH-1:0][WIDTH-1:0]: write data; WD[i] is lane i.
REQ-009 SHALL have port WEV, input, 1 bit: vector write enable, active-high.
REQ-010 SHALL have port RD1, output, packed [WIDTH-1:0][WIDTH-1:0]: read data for RS1.
REQ-011 SHALL have port RD2, output, packed [WIDTH-1:0][WIDTH-1:0]: read data for RS2.
REQ-012 SHALL have port RD3, output, packed [WIDTH-1:0][WIDTH-1:0]: read data for RS3.

Function
REQ-013 SHALL hold 32 vector registers v0..v31, each WIDTH lanes of WIDTH bits (16x16 = 256 bits at default).
REQ-014 SHALL treat all 32 registers, including v0, as ordinary writable registers; v0 is not hardwired to zero.
REQ-015 SHALL drive RD1/RD2/RD3 combinationally from the registers addressed by RS1/RS2/RS3, with zero-cycle latency and no clock dependence.
REQ-016 SHALL allow all three read ports to address the same or different registers simultaneously and independently.
REQ-017 SHALL write the full WD vector (all lanes) into register RD on a rising clk edge when WEV=1 and rst=0.
REQ-018 SHALL leave every register unchanged on a rising edge when WEV=0.
REQ-019 SHALL not bypass write data to reads: when RSx equals RD during a write cycle, RDx shows the old contents until the edge, then the new contents.
REQ-020 SHALL not support lane masking; every write replaces all lanes of the addressed register.
REQ-021 SHALL preserve lane ordering: WD[i] is stored in lane i and appears on RDx[i].

Reset
REQ-022 SHALL clear all 32 registers to zero on a rising clk edge while rst=1.
REQ-023 SHALL give rst priority over WEV; a write requested in a reset cycle is discarded.
REQ-024 SHALL drive all three read outputs to zero after reset for any read addresses, as a consequence of REQ-022 and REQ-015.
REQ-025 SHALL honour rst asserted at any time, including mid-sequence, with the same effect on the next rising edge; no asynchronous effect before the edge.

Verification
REQ-026 SHALL pass this check: rst=1 for 2 edges, then rst=0; RS1=0, RS2=15, RS3=31 -> RD1=RD2=RD3=0.
REQ-027 SHALL pass this check: WEV=1, RD=1, all 16 lanes of WD=16'hCCCC, one edge; WEV=0; RS1=1, RS2=0, RS3=0 -> RD1 lanes all 16'hCCCC, RD2=RD3=0.
REQ-028 SHALL pass this check: WEV=0, RD=2, WD lanes=16'hFFFF, one edge; RS1=2 -> RD1=0.
REQ-029 SHALL pass this check: RS1=RS2=RS3=5; WEV=1, RD=5, WD lane i=i; before the edge RD1=RD2=RD3=0; after the edge all three outputs show lane i=i.
REQ-030 SHALL pass this check: write 16'hA5A5 to all lanes of v0 and v31, then rst=1 and WEV=1 with RD=3 for one edge; RS1=0, RS2=31, RS3=3 -> all outputs 0.
REQ-031 SHALL pass this check: write 16'h1234 to all lanes of v7 and then 16'h5678 to all lanes of v7 on consecutive edges; RS1=7 -> 16'h5678 in all lanes; other registers remain 0.
